// File: rtl/friscv_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// friscv_pkg : shared constants and types for the friscv core
// Rev 1.0
// ------------------------------------------------------------------
package friscv_pkg;

  localparam int ARCH = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } dmem_state_t;

  // Reserved size codes fall through to a full word.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3)
      LB, LBU: size_mask = 4'b0001;
      LH, LHU: size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3)
      LB, LBU: size_bytes = 3'd1;
      LH, LHU: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_align.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_load_align : extracts and extends load data from two words
// Rev 1.0
// ------------------------------------------------------------------
module dmem_load_align
  import friscv_pkg::*;
(
  input  logic [31:0]     w0,
  input  logic [31:0]     w1,
  input  logic [1:0]      offset,
  input  logic [2:0]      func3,
  output logic [ARCH-1:0] data_out
);

  logic [31:0] w_sh;

  assign w_sh = 32'({w1, w0} >> {offset, 3'b000});

  always_comb begin
    data_out = w_sh;
    case (func3)
      LB:      data_out = {{24{w_sh[7]}}, w_sh[7:0]};
      LH:      data_out = {{16{w_sh[15]}}, w_sh[15:0]};
      LBU:     data_out = {24'h000000, w_sh[7:0]};
      LHU:     data_out = {16'h0000, w_sh[15:0]};
      default: data_out = w_sh;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_ctrl : core load/store to req/gnt/rvalid memory port bridge
// Rev 1.0
// ------------------------------------------------------------------
module dmem_ctrl
  import friscv_pkg::*;
#(
  parameter int MEM_ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_in,
  input  logic                  we_in,
  input  logic [ARCH-1:0]       addr_in,
  input  logic [ARCH-1:0]       wdata_in,
  input  logic [2:0]            func3_in,
  output logic [ARCH-1:0]       rdata_out,
  output logic                  done_out,
  output logic                  stall_out,
  output logic                  mem_req_out,
  output logic                  mem_we_out,
  output logic [MEM_ADDR_W-1:0] mem_addr_out,
  output logic [3:0]            mem_be_out,
  output logic [31:0]           mem_wdata_out,
  input  logic                  mem_gnt_in,
  input  logic                  mem_rvalid_in,
  input  logic [31:0]           mem_rdata_in
);

  dmem_state_t           r_state, w_state_n;
  logic                  r_ph, w_ph_n;
  logic                  r_we, w_we_n;
  logic [ARCH-1:0]       r_addr, w_addr_n;
  logic [ARCH-1:0]       r_wdata, w_wdata_n;
  logic [2:0]            r_f3, w_f3_n;
  logic [31:0]           r_w0, w_w0_n;
  logic [31:0]           r_w1, w_w1_n;
  logic                  w_split;
  logic                  w_issue_n;
  logic [1:0]            w_off_n;
  logic [7:0]            w_be8_n;
  logic [63:0]           w_wd64_n;
  logic [MEM_ADDR_W-1:0] w_word_n;
  logic [ARCH-1:0]       w_ld_data;
  logic                  w_unused;

  assign w_split   = ({2'b00, r_addr[1:0]} + {1'b0, size_bytes(r_f3)}) > 4'd4;
  assign stall_out = req_in & ~done_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_ph_n    = r_ph;
    w_we_n    = r_we;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    w_f3_n    = r_f3;
    w_w0_n    = r_w0;
    w_w1_n    = r_w1;
    case (r_state)
      IDLE: begin
        if (req_in) begin
          w_we_n    = we_in;
          w_addr_n  = addr_in;
          w_wdata_n = wdata_in;
          w_f3_n    = func3_in;
          w_ph_n    = 1'b0;
          w_state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt_in) begin
          if (!r_we)                w_state_n = RWAIT;
          else if (w_split && !r_ph) w_ph_n   = 1'b1;
          else                      w_state_n = DONE;
        end
      end
      RWAIT: begin
        if (mem_rvalid_in) begin
          if (r_ph) w_w1_n = mem_rdata_in;
          else      w_w0_n = mem_rdata_in;
          if (w_split && !r_ph) begin
            w_ph_n    = 1'b1;
            w_state_n = ISSUE;
          end else begin
            w_state_n = DONE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Memory-side outputs are registered from the next-state view so they
  // appear in the same cycle the FSM enters ISSUE.
  assign w_issue_n = (w_state_n == ISSUE);
  assign w_off_n   = w_addr_n[1:0];
  assign w_be8_n   = {4'b0000, size_mask(w_f3_n)} << w_off_n;
  assign w_wd64_n  = {32'h0000_0000, w_wdata_n} << {w_off_n, 3'b000};
  assign w_word_n  = w_addr_n[MEM_ADDR_W+1:2] + {{(MEM_ADDR_W-1){1'b0}}, w_ph_n};
  assign w_unused  = ^w_addr_n;

  dmem_load_align u_align (
    .w0      (w_w0_n),
    .w1      (w_w1_n),
    .offset  (w_off_n),
    .func3   (w_f3_n),
    .data_out(w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph          <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_f3          <= 3'b000;
      r_w0          <= 32'h0;
      r_w1          <= 32'h0;
      mem_req_out   <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_be_out    <= 4'b0000;
      mem_wdata_out <= 32'h0;
      done_out      <= 1'b0;
      rdata_out     <= '0;
    end else begin
      r_ph          <= w_ph_n;
      r_we          <= w_we_n;
      r_addr        <= w_addr_n;
      r_wdata       <= w_wdata_n;
      r_f3          <= w_f3_n;
      r_w0          <= w_w0_n;
      r_w1          <= w_w1_n;
      mem_req_out   <= w_issue_n;
      mem_we_out    <= w_issue_n & w_we_n;
      mem_addr_out  <= w_issue_n ? w_word_n : '0;
      mem_be_out    <= w_issue_n ? (w_ph_n ? w_be8_n[7:4] : w_be8_n[3:0]) : 4'b0000;
      mem_wdata_out <= w_issue_n ? (w_ph_n ? w_wd64_n[63:32] : w_wd64_n[31:0]) : 32'h0;
      done_out      <= (w_state_n == DONE);
      if ((w_state_n == DONE) && !w_we_n) rdata_out <= w_ld_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_dmem_ctrl : randomized self-checking bench with byte-level model
// Rev 1.0
// ------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam int AW   = 16;
  localparam int MEMB = 1 << (AW + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_in, we_in;
  logic [31:0]   addr_in, wdata_in;
  logic [2:0]    func3_in;
  logic [31:0]   rdata_out;
  logic          done_out, stall_out;
  logic          mem_req_out, mem_we_out;
  logic [AW-1:0] mem_addr_out;
  logic [3:0]    mem_be_out;
  logic [31:0]   mem_wdata_out;
  logic          mem_gnt_in, mem_rvalid_in;
  logic [31:0]   mem_rdata_in;

  dmem_ctrl #(.MEM_ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_in       (req_in),
    .we_in        (we_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .func3_in     (func3_in),
    .rdata_out    (rdata_out),
    .done_out     (done_out),
    .stall_out    (stall_out),
    .mem_req_out  (mem_req_out),
    .mem_we_out   (mem_we_out),
    .mem_addr_out (mem_addr_out),
    .mem_be_out   (mem_be_out),
    .mem_wdata_out(mem_wdata_out),
    .mem_gnt_in   (mem_gnt_in),
    .mem_rvalid_in(mem_rvalid_in),
    .mem_rdata_in (mem_rdata_in)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:MEMB-1];
  logic [31:0] last_rdata;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int nbytes_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] rd_word(input logic [AW-1:0] w);
    int b;
    b = int'(w) * 4;
    return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
  endfunction

  // Entered and left just after a falling edge; serves the memory port
  // with the given grant waits and rvalid delays per word.
  task automatic do_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] f3, input int gd0, input int gd1,
                           input int rd0, input int rd1, input bit drop);
    int nb, o, ntx, tx, waitc, rvwait, cyc, exp_done, p;
    bit rvpend, done_seen, stall_bad, hold_bad;
    logic [AW-1:0] words [2];
    logic [3:0]    ebe [2];
    logic [31:0]   ewd [2];
    logic [31:0]   exp_rd;
    int gd [2];
    int rd [2];
    gd[0] = gd0; gd[1] = gd1; rd[0] = rd0; rd[1] = rd1;
    nb  = nbytes_of(f3);
    o   = int'(a[1:0]);
    ntx = (o + nb > 4) ? 2 : 1;
    words[0] = a[AW+1:2];
    words[1] = words[0] + 1'b1;
    for (int t = 0; t < 2; t++) begin
      ebe[t] = 4'b0000;
      ewd[t] = 32'h0;
      for (int l = 0; l < 4; l++) begin
        int k;
        k = t * 4 + l - o;
        if (k >= 0 && k < 4)  ewd[t][8*l +: 8] = wd[8*k +: 8];
        if (k >= 0 && k < nb) ebe[t][l] = 1'b1;
      end
    end
    exp_rd = 32'h0;
    for (int k = 0; k < nb; k++) begin
      p = o + k;
      exp_rd[8*k +: 8] = mem[int'(words[p/4]) * 4 + (p % 4)];
    end
    if (f3 == 3'b000 && exp_rd[7])  exp_rd[31:8]  = 24'hFFFFFF;
    if (f3 == 3'b001 && exp_rd[15]) exp_rd[31:16] = 16'hFFFF;
    if (we)
      for (int k = 0; k < nb; k++) begin
        p = o + k;
        mem[int'(words[p/4]) * 4 + (p % 4)] = wd[8*k +: 8];
      end
    exp_done = 1;
    for (int t = 0; t < ntx; t++) exp_done += we ? (1 + gd[t]) : (2 + gd[t] + rd[t]);

    req_in = 1'b1; we_in = we; addr_in = a; wdata_in = wd; func3_in = f3;
    mem_gnt_in = 1'b0; mem_rvalid_in = 1'b0;
    cyc = 0; tx = 0; waitc = 0; rvwait = 0;
    rvpend = 0; done_seen = 0; stall_bad = 0; hold_bad = 0;
    while (!done_seen) begin
      @(negedge clk);
      cyc++;
      if (stall_out !== (req_in && cyc != exp_done)) stall_bad = 1;
      mem_gnt_in = 1'b0; mem_rvalid_in = 1'b0; mem_rdata_in = $urandom;
      if (done_out) begin
        done_seen = 1;
        check("done_cycle", 32'(cyc), 32'(exp_done));
        check("tx_count", 32'(tx), 32'(ntx));
        if (!we) last_rdata = exp_rd;
        check("rdata", rdata_out, last_rdata);
        req_in = 1'b0;
      end else if (mem_req_out) begin
        if (tx >= ntx) hold_bad = 1;
        else begin
          if ({mem_addr_out, mem_be_out, mem_wdata_out, mem_we_out} !==
              {words[tx], ebe[tx], ewd[tx], we}) hold_bad = 1;
          if (waitc == gd[tx]) begin
            check("addr", 32'(mem_addr_out), 32'(words[tx]));
            check("be", 32'(mem_be_out), 32'(ebe[tx]));
            check("wdata", mem_wdata_out, ewd[tx]);
            check("we", 32'(mem_we_out), 32'(we));
            mem_gnt_in = 1'b1;
            tx++;
            waitc = 0;
            if (!we) begin rvpend = 1; rvwait = 0; end
          end else begin
            waitc++;
            mem_rvalid_in = 1'($urandom_range(0, 1));
          end
        end
      end else if (rvpend) begin
        if (rvwait == rd[tx-1]) begin
          mem_rvalid_in = 1'b1;
          mem_rdata_in  = rd_word(words[tx-1]);
          rvpend = 0;
        end else rvwait++;
      end else begin
        mem_gnt_in = 1'($urandom_range(0, 1));
      end
      if (drop && cyc == 2) req_in = 1'b0;
      if (!done_seen && cyc > 80) begin
        check("timeout", 32'(cyc), 32'(exp_done));
        req_in = 1'b0;
        break;
      end
    end
    @(negedge clk);
    check("done_pulse", 32'({done_out, mem_req_out}), 32'd0);
    check("stall", 32'(stall_bad), 32'd0);
    check("hold", 32'(hold_bad), 32'd0);
    mem_gnt_in    = 1'($urandom_range(0, 1));
    mem_rvalid_in = 1'($urandom_range(0, 1));
  endtask

  task automatic reset_mid_load();
    int c;
    req_in = 1'b1; we_in = 1'b0; addr_in = 32'h300; func3_in = 3'b010;
    mem_gnt_in = 1'b0; mem_rvalid_in = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!mem_req_out && c < 10);
    check("rst_seq_req", 32'(mem_req_out), 32'd1);
    mem_gnt_in = 1'b1;
    @(negedge clk);
    mem_gnt_in = 1'b0;
    check("rst_seq_rwait", 32'(mem_req_out), 32'd0);
    rst = 1'b1; req_in = 1'b0;
    #1;
    check("rst_ctl", 32'({mem_req_out, mem_we_out, done_out, mem_be_out}), 32'd0);
    check("rst_addr", 32'(mem_addr_out), 32'd0);
    check("rst_wdata", mem_wdata_out, 32'd0);
    check("rst_rdata", rdata_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rvalid_in = 1'b1; mem_rdata_in = 32'hCAFEF00D;
    @(negedge clk);
    mem_rvalid_in = 1'b0;
    repeat (2) @(negedge clk);
    check("stale_rv_done", 32'({done_out, mem_req_out}), 32'd0);
    check("stale_rv_rdata", rdata_out, 32'd0);
    last_rdata = 32'h0;
  endtask

  initial begin
    logic [31:0] ra, rw;
    logic [2:0]  rf;
    bit          rwe;
    for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);
    rst = 1'b1; req_in = 1'b0; we_in = 1'b0; addr_in = 32'h0; wdata_in = 32'h0;
    func3_in = 3'b000; mem_gnt_in = 1'b0; mem_rvalid_in = 1'b0; mem_rdata_in = 32'h0;
    last_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_ctl", 32'({mem_req_out, mem_we_out, done_out, mem_be_out}), 32'd0);
    check("reset_addr", 32'(mem_addr_out), 32'd0);
    check("reset_wdata", mem_wdata_out, 32'd0);
    check("reset_rdata", rdata_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_access(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 0, 0, 0, 1'b0);
    check("sw_mem", rd_word(16'h0040), 32'hDEADBEEF);

    mem[32'h100] = 8'h00; mem[32'h101] = 8'h00; mem[32'h102] = 8'hFF; mem[32'h103] = 8'h80;
    do_access(1'b0, 32'h103, 32'h0, 3'b000, 0, 0, 0, 0, 1'b0);
    check("lb_value", rdata_out, 32'hFFFFFF80);
    do_access(1'b0, 32'h103, 32'h0, 3'b100, 1, 0, 0, 0, 1'b0);
    check("lbu_value", rdata_out, 32'h00000080);

    do_access(1'b1, 32'h106, 32'h11223344, 3'b010, 0, 0, 0, 0, 1'b0);
    check("sw_split_w41", rd_word(16'h0041) & 32'hFFFF0000, 32'h33440000);

    mem[32'hFC] = 8'h00; mem[32'hFD] = 8'h00; mem[32'hFE] = 8'h00; mem[32'hFF] = 8'hAB;
    mem[32'h100] = 8'hCD; mem[32'h101] = 8'h00; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
    do_access(1'b0, 32'h0FF, 32'h0, 3'b001, 0, 0, 0, 0, 1'b0);
    check("lh_split_value", rdata_out, 32'hFFFFCDAB);
    do_access(1'b0, 32'h3FFFF, 32'h0, 3'b001, 1, 0, 1, 0, 1'b0);

    do_access(1'b0, 32'h204, 32'h0, 3'b010, 3, 0, 1, 0, 1'b1);
    do_access(1'b1, 32'h20B, 32'hA5A55A5A, 3'b010, 3, 2, 0, 0, 1'b1);
    do_access(1'b0, 32'h20A, 32'h0, 3'b010, 2, 3, 3, 1, 1'b0);

    repeat (250) begin
      rwe = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 63)) : $urandom;
      rw  = $urandom;
      rf  = 3'($urandom);
      do_access(rwe, ra, rw, rf, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    do_access(1'b0, 32'h100, 32'h0, 3'b010, 0, 0, 0, 0, 1'b0);
    reset_mid_load();
    do_access(1'b0, 32'h200, 32'h0, 3'b010, 0, 0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
